// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: state encodings,
// control-bundle encodings and fixed pipeline constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MULDIV     = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_e;

  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int          MULDIV_LAT_DEF = 32;

  // Pipeline-register steering; IF_ID enable is inverted (1 = do not capture).
  typedef struct packed {
    logic pc_write;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_PASS  = '{pc_write: 1'b1, if_id_enable: 1'b0,
                                   if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_HOLD  = '{pc_write: 1'b0, if_id_enable: 1'b1,
                                   if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_enable: 1'b0,
                                   if_id_flush: 1'b1, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_enable: 1'b1,
                                   if_id_flush: 1'b1, id_ex_bubble: 1'b1};

endpackage

// File: rtl/hazard_ctrl_load_use_cmp.sv
// Load-use detector: a load in EX writing a register read by the instruction in ID.
// Purely combinational; writes to the zero register never create a hazard.
module load_use_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic       i_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = (i_ex_rt == i_id_rt);
  assign o_hazard   = i_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, multiply/divide, fetch-wait stalls and branch flush.
// Controls are decoded combinationally from state and inputs so they settle before the negedge sampling point.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_ready,
  input  logic             muldiv_start,
  output logic             PC_write,
  output logic             IF_ID_enable,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic             w_load_use;
  logic             w_redirect;

  load_use_cmp u_load_use_cmp (
    .i_mem_read (ID_EX_MemRead),
    .i_ex_rt    (ID_EX_Rt),
    .i_id_rs    (IF_ID_Rs),
    .i_id_rt    (IF_ID_Rt),
    .o_hazard   (w_load_use)
  );

  assign w_redirect = branch_taken | jump;

  always_comb begin
    w_ctrl       = CTRL_PASS;
    w_next_state = ST_RUN;
    w_next_cnt   = '0;
    unique case (r_state)
      // A MEM_WAIT cycle with the fetch complete is decoded exactly like RUN.
      ST_RUN, ST_MEM_WAIT: begin
        if (!mem_ready) begin
          w_ctrl       = CTRL_HOLD;
          w_next_state = ST_MEM_WAIT;
        end else if (muldiv_start) begin
          w_ctrl       = CTRL_HOLD;
          w_next_state = ST_MULDIV;
          w_next_cnt   = MULDIV_LOAD;
        end else if (w_load_use) begin
          w_ctrl       = CTRL_HOLD;
          w_next_state = ST_LOAD_STALL;
        end else if (w_redirect) begin
          w_ctrl       = CTRL_FLUSH;
        end
      end
      // The bubble is already in EX, so the dependent instruction may advance.
      ST_LOAD_STALL: begin
        w_ctrl = w_redirect ? CTRL_FLUSH : CTRL_PASS;
      end
      ST_MULDIV: begin
        if (r_cnt != '0) begin
          w_ctrl       = CTRL_HOLD;
          w_next_state = ST_MULDIV;
          w_next_cnt   = r_cnt - CNT_W'(1);
        end else if (!mem_ready) begin
          w_ctrl       = CTRL_HOLD;
          w_next_state = ST_MEM_WAIT;
        end
      end
      default: begin
        w_ctrl       = CTRL_HOLD;
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Reset overrides the decode immediately rather than waiting for a clock.
  assign w_out        = rst_n ? w_ctrl : CTRL_RESET;
  assign PC_write     = w_out.pc_write;
  assign IF_ID_enable = w_out.if_id_enable;
  assign IF_ID_flush  = w_out.if_id_flush;
  assign ID_EX_bubble = w_out.id_ex_bubble;
  assign busy         = rst_n && (r_state != ST_RUN);
  assign stall_cnt    = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control vectors checked after each edge.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       branch_taken;
  logic       jump;
  logic       mem_ready;
  logic       muldiv_start;
  logic       PC_write;
  logic       IF_ID_enable;
  logic       IF_ID_flush;
  logic       ID_EX_bubble;
  logic       busy;
  logic [5:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // {PC_write, IF_ID_enable, IF_ID_flush, ID_EX_bubble}
  localparam logic [3:0] E_PASS  = 4'b1000;
  localparam logic [3:0] E_HOLD  = 4'b0101;
  localparam logic [3:0] E_FLUSH = 4'b1010;
  localparam logic [3:0] E_RST   = 4'b0111;

  hazard_ctrl #(.MULDIV_LAT(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rt     (ID_EX_Rt),
    .IF_ID_Rs     (IF_ID_Rs),
    .IF_ID_Rt     (IF_ID_Rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mem_ready    (mem_ready),
    .muldiv_start (muldiv_start),
    .PC_write     (PC_write),
    .IF_ID_enable (IF_ID_enable),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_bubble (ID_EX_bubble),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ctrl, input logic b, input int cnt);
    chk({tag, ".ctrl"}, {28'd0, PC_write, IF_ID_enable, IF_ID_flush, ID_EX_bubble}, {28'd0, ctrl});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  task automatic idle();
    ID_EX_MemRead = 1'b0;
    ID_EX_Rt      = 5'd0;
    IF_ID_Rs      = 5'd0;
    IF_ID_Rt      = 5'd0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
    mem_ready     = 1'b1;
    muldiv_start  = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
    ID_EX_MemRead = 1'b1;
    ID_EX_Rt      = ert;
    IF_ID_Rs      = rs;
    IF_ID_Rt      = rt;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    expect_out("reset", E_RST, 1'b0, 0);
    cyc();
    expect_out("reset_held", E_RST, 1'b0, 0);
    rst_n = 1'b1;
    #1;
    expect_out("post_reset", E_PASS, 1'b0, 0);
    cyc();

    // Load-use on Rs: one hold cycle, then pass while ID still presents the match.
    load_use(5'd8, 5'd8, 5'd3); #1;
    expect_out("lu_rs_hold", E_HOLD, 1'b0, 0);
    cyc(); #1;
    expect_out("lu_rs_stall", E_PASS, 1'b1, 0);
    cyc(); idle(); #1;
    expect_out("lu_rs_after", E_PASS, 1'b0, 0);
    cyc();

    // Zero register never stalls.
    load_use(5'd0, 5'd0, 5'd0); #1;
    expect_out("lu_zero", E_PASS, 1'b0, 0);
    cyc(); #1;
    expect_out("lu_zero_next", E_PASS, 1'b0, 0);
    cyc();

    // Load-use on Rt.
    load_use(5'd9, 5'd1, 5'd9); #1;
    expect_out("lu_rt_hold", E_HOLD, 1'b0, 0);
    cyc(); idle(); #1;
    expect_out("lu_rt_stall", E_PASS, 1'b1, 0);
    cyc();

    // Non-matching load passes.
    load_use(5'd7, 5'd6, 5'd5); #1;
    expect_out("lu_nomatch", E_PASS, 1'b0, 0);
    cyc(); idle();

    // Branch and jump flush for one cycle.
    branch_taken = 1'b1; #1;
    expect_out("branch", E_FLUSH, 1'b0, 0);
    cyc(); idle(); #1;
    expect_out("branch_after", E_PASS, 1'b0, 0);
    cyc();
    jump = 1'b1; #1;
    expect_out("jump", E_FLUSH, 1'b0, 0);
    cyc(); idle();

    // Load-use plus branch: stall first, then the re-presented branch flushes.
    load_use(5'd8, 5'd8, 5'd0); branch_taken = 1'b1; #1;
    expect_out("lu_br_hold", E_HOLD, 1'b0, 0);
    cyc(); #1;
    expect_out("lu_br_flush", E_FLUSH, 1'b1, 0);
    cyc(); idle(); #1;
    expect_out("lu_br_after", E_PASS, 1'b0, 0);
    cyc();

    // mem_ready low for three cycles: three holds, then the resume cycle passes.
    mem_ready = 1'b0; #1;
    expect_out("mw_1", E_HOLD, 1'b0, 0);
    cyc(); #1;
    expect_out("mw_2", E_HOLD, 1'b1, 0);
    cyc(); #1;
    expect_out("mw_3", E_HOLD, 1'b1, 0);
    cyc(); mem_ready = 1'b1; #1;
    expect_out("mw_resume", E_PASS, 1'b1, 0);
    cyc(); #1;
    expect_out("mw_after", E_PASS, 1'b0, 0);
    cyc();

    // Resume cycle is evaluated as RUN, so a branch there flushes.
    mem_ready = 1'b0; #1;
    cyc(); mem_ready = 1'b1; branch_taken = 1'b1; #1;
    expect_out("mw_branch", E_FLUSH, 1'b1, 0);
    cyc(); idle();

    // Multiply/divide: issue hold, then 31 held cycles with other inputs ignored.
    muldiv_start = 1'b1; #1;
    expect_out("md1_issue", E_HOLD, 1'b0, 0);
    cyc(); muldiv_start = 1'b0;
    load_use(5'd8, 5'd8, 5'd0); branch_taken = 1'b1;
    for (int i = 31; i >= 1; i--) begin
      if (i == 10) mem_ready = 1'b0;
      if (i == 5)  mem_ready = 1'b1;
      #1;
      expect_out($sformatf("md1_cnt%0d", i), E_HOLD, 1'b1, i);
      cyc();
    end
    idle(); #1;
    expect_out("md1_done", E_PASS, 1'b1, 0);
    cyc(); #1;
    expect_out("md1_after", E_PASS, 1'b0, 0);
    cyc();

    // Multiply/divide ending with fetch not ready continues into MEM_WAIT.
    muldiv_start = 1'b1; #1;
    cyc(); muldiv_start = 1'b0;
    for (int i = 31; i >= 1; i--) begin
      if (i == 3) mem_ready = 1'b0;
      cyc();
    end
    #1;
    expect_out("md2_end_hold", E_HOLD, 1'b1, 0);
    cyc(); #1;
    expect_out("md2_memwait", E_HOLD, 1'b1, 0);
    cyc(); mem_ready = 1'b1; #1;
    expect_out("md2_resume", E_PASS, 1'b1, 0);
    cyc(); #1;
    expect_out("md2_after", E_PASS, 1'b0, 0);
    cyc();

    // Reset asserted at stall_cnt=10 aborts the operation within the cycle.
    muldiv_start = 1'b1; #1;
    cyc(); muldiv_start = 1'b0;
    for (int i = 31; i >= 11; i--) cyc();
    #1;
    expect_out("md3_cnt10", E_HOLD, 1'b1, 10);
    rst_n = 1'b0; #1;
    expect_out("md3_rst", E_RST, 1'b0, 0);
    cyc(); #1;
    rst_n = 1'b1; #1;
    expect_out("md3_release", E_PASS, 1'b0, 0);
    cyc(); #1;
    expect_out("md3_no_pending", E_PASS, 1'b0, 0);
    cyc();

    // Reset during MEM_WAIT leaves no pending wait.
    mem_ready = 1'b0; #1;
    cyc(); #1;
    expect_out("mw_rst_pre", E_HOLD, 1'b1, 0);
    rst_n = 1'b0; #1;
    expect_out("mw_rst", E_RST, 1'b0, 0);
    mem_ready = 1'b1;
    cyc(); rst_n = 1'b1; #1;
    expect_out("mw_rst_release", E_PASS, 1'b0, 0);
    cyc(); #1;
    expect_out("mw_rst_after", E_PASS, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 32, multiply/divide stall length in cycles (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 6, width of the stall counter (ceil(log2(MULDIV_LAT)) minimum).
REQ-003 SHALL have port clk, input, 1, single clock; the state register updates on posedge, and all outputs are stable before the following negedge, where pipeline registers sample.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ID_EX_MemRead, input, 1, load instruction in EX.
REQ-006 SHALL have port ID_EX_Rt, input, 5, destination register of the load in EX.
REQ-007 SHALL have ports IF_ID_Rs and IF_ID_Rt, input, 5 each, source registers of the instruction in ID.
REQ-008 SHALL have port branch_taken, input, 1, branch resolved taken in ID.
REQ-009 SHALL have port jump, input, 1, jump decoded in ID.
REQ-010 SHALL have port mem_ready, input, 1, instruction memory ready; 0 means the fetch is not complete.
REQ-011 SHALL have port muldiv_start, input, 1, multiply/divide issued from ID.
REQ-012 SHALL have port PC_write, output, 1: 1 = PC updates; 0 = PC holds.
REQ-013 SHALL have port IF_ID_enable, output, 1: 0 = IF_ID captures; 1 = IF_ID does not capture.
REQ-014 SHALL have port IF_ID_flush, output, 1: IF_ID loads NOP (32'h00000000).
REQ-015 SHALL have port ID_EX_bubble, output, 1: ID_EX loads zeroed control.
REQ-016 SHALL have port busy, output, 1: state is not RUN.
REQ-017 SHALL have port stall_cnt, output, CNT_W: remaining multiply/divide stall cycles.

Function
REQ-018 SHALL implement four states: RUN, LOAD_STALL, MULDIV and MEM_WAIT.
REQ-019 SHALL define "hold" as PC_write=0, IF_ID_enable=1, IF_ID_flush=0 and ID_EX_bubble=1.
REQ-020 SHALL define "pass" as PC_write=1, IF_ID_enable=0, IF_ID_flush=0 and ID_EX_bubble=0.
REQ-021 SHALL define a load-use hazard as ID_EX_MemRead=1, ID_EX_Rt!=0, and ID_EX_Rt equal to either IF_ID_Rs or IF_ID_Rt.
REQ-022 SHALL, in RUN, apply this priority: mem_ready=0 > muldiv_start > load-use > (branch_taken|jump) > pass.
REQ-023 SHALL, in RUN with mem_ready=0, drive hold and go to MEM_WAIT.
REQ-024 SHALL, in RUN with muldiv_start, drive hold, load stall_cnt=MULDIV_LAT-1 and go to MULDIV.
REQ-025 SHALL, in RUN with a load-use hazard, drive hold and go to LOAD_STALL.
REQ-026 SHALL, in RUN with branch_taken or jump, drive PC_write=1, IF_ID_enable=0 and IF_ID_flush=1 for exactly one cycle, and stay in RUN.
REQ-027 SHALL, in LOAD_STALL, drive pass without re-evaluating load-use, and return to RUN after one cycle (total stall = 1 cycle).
REQ-028 SHALL, in LOAD_STALL, honour branch_taken|jump by applying the flush of REQ-026.
REQ-029 SHALL, in MULDIV, drive hold and decrement stall_cnt each cycle while stall_cnt!=0, ignoring all other inputs.
REQ-030 SHALL, in MULDIV with stall_cnt==0, go to RUN when mem_ready=1 or to MEM_WAIT when mem_ready=0 (total stall = MULDIV_LAT cycles).
REQ-031 SHALL, in MEM_WAIT, drive hold and return to RUN on the first cycle with mem_ready=1; that cycle is evaluated as RUN.
REQ-032 SHALL, when a load-use hazard and a taken branch coincide, stall first; the branch is re-presented and flushed afterwards.
REQ-033 SHALL hold stall_cnt at 0 outside MULDIV.

Reset
REQ-034 SHALL, while rst_n=0, force state=RUN, stall_cnt=0, PC_write=0, IF_ID_enable=1, IF_ID_flush=1, ID_EX_bubble=1 and busy=0, asynchronously.
REQ-035 SHALL, on reset assertion mid-MULDIV or mid-MEM_WAIT, abandon the operation immediately, with no pending stall after release.
REQ-036 SHALL drive pass on the first posedge after release, provided the inputs are idle.

Structure
REQ-037 SHALL take the state encodings, NOP value, REG_ZERO (5'd0) and the default MULDIV_LAT from the shared pipeline definitions package/include.
REQ-038 SHALL place the load-use comparison in one combinational sub-module, load_use_cmp.

Verification
REQ-039 SHALL cover: MemRead=1, ID_EX_Rt=5'd8, IF_ID_Rs=5'd8 in RUN -> exactly 1 hold cycle, then pass.
REQ-040 SHALL cover: same as REQ-039 with ID_EX_Rt=0 and IF_ID_Rs=0 -> no stall.
REQ-041 SHALL cover: muldiv_start=1 with MULDIV_LAT=32 -> 32 hold cycles, stall_cnt 31..0, busy high throughout, then pass.
REQ-042 SHALL cover: branch_taken=1 in RUN -> IF_ID_flush=1 and PC_write=1 for 1 cycle; load-use plus branch together -> hold, then flush.
REQ-043 SHALL cover: mem_ready=0 for 3 cycles during RUN -> 3 hold cycles in MEM_WAIT; MULDIV ending with mem_ready=0 -> MEM_WAIT.
REQ-044 SHALL cover: rst_n=0 asserted at stall_cnt=10 -> outputs forced to reset values within the same cycle, stall_cnt=0, RUN after release.
